// File: rtl/dm_uart_dumper.sv
// dm_uart_dumper: reads a block of data memory and streams each byte out as an 8N1 UART frame
module dm_uart_dumper #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              bus_req,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, START, DATA, STOP, FIN} state_t;
  state_t state;
  logic [CW-1:0] baud;
  logic [2:0] bit_idx;
  logic [DATA_W-1:0] shift;
  logic [ADDR_W:0] remaining;
  logic bit_end;
  assign bit_end = baud == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      remaining <= '0;
      mem_addr <= '0;
      bus_req <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          remaining <= count;
          mem_addr <= base_addr;
          busy <= 1'b1;
          if (count == '0) begin
            done <= 1'b1;
            state <= FIN;
          end else begin
            bus_req <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: state <= WAIT;
        WAIT: state <= LOAD;
        LOAD: begin
          shift <= mem_rd_data;
          bus_req <= 1'b0;
          tx <= 1'b0;
          baud <= '0;
          state <= START;
        end
        START: if (bit_end) begin
          baud <= '0;
          tx <= shift[0];
          bit_idx <= '0;
          state <= DATA;
        end else baud <= baud + 1'b1;
        DATA: if (bit_end) begin
          baud <= '0;
          if (bit_idx == 3'd7) begin
            tx <= 1'b1;
            state <= STOP;
          end else begin
            tx <= shift[1];
            shift <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end else baud <= baud + 1'b1;
        STOP: if (bit_end) begin
          baud <= '0;
          remaining <= remaining - 1'b1;
          if (remaining == (ADDR_W+1)'(1)) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= FIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            bus_req <= 1'b1;
            state <= ADDR;
          end
        end else baud <= baud + 1'b1;
        FIN: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_uart_dumper.sv
// tb_dm_uart_dumper: directed checks of the memory-to-UART dumper with a UART receiver model
module tb_dm_uart_dumper;
  localparam int CPB = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b1;
  logic [7:0] base_addr = 8'h55;
  logic [8:0] count = 9'd3;
  logic [7:0] mem_addr, mem_rd_data;
  logic bus_req, tx, busy, done;
  logic [7:0] mem [0:255];
  logic [7:0] rx_q[$], addr_q[$];
  int done_cnt = 0, frame_err = 0, passed = 0, total = 0, rx_cnt = 0;
  logic rx_on = 1'b0, prev_tx = 1'b1, prev_bus = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  always #5 clk = ~clk;

  dm_uart_dumper #(.ADDR_W(8), .DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .bus_req(bus_req),
    .tx(tx), .busy(busy), .done(done)
  );

  always @(posedge clk) mem_rd_data <= mem[mem_addr];

  // UART receiver: samples mid-bit, one sample per cycle, CPB = 4
  always @(negedge clk) begin
    #1;
    if (rst) rx_on = 1'b0;
    else begin
      if (done === 1'b1) done_cnt++;
      if (bus_req === 1'b1 && !prev_bus) addr_q.push_back(mem_addr);
      if (rx_on) begin
        rx_cnt++;
        if (rx_cnt == 2 && tx !== 1'b0) begin
          frame_err++;
          rx_on = 1'b0;
        end else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 6) % 4 == 0) rx_byte = {tx, rx_byte[7:1]};
        else if (rx_cnt == 38) begin
          if (tx === 1'b1) rx_q.push_back(rx_byte);
          else frame_err++;
          rx_on = 1'b0;
        end
      end else if (tx === 1'b0 && prev_tx) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end
    prev_tx = tx;
    prev_bus = bus_req;
  end

  task automatic kick(input logic [7:0] b, input logic [8:0] c);
    @(negedge clk);
    base_addr = b;
    count = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (done !== 1'b1) $display("FAIL done_timeout got done=%b want 1 within %0d cycles", done, limit);
    else passed++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bus_req !== 1'b0 || mem_addr !== 8'h00)
      $display("FAIL reset_values got tx=%b busy=%b done=%b bus_req=%b mem_addr=%h want 1 0 0 0 00", tx, busy, done, bus_req, mem_addr);
    else passed++;
    rst = 1'b0;
    start = 1'b0;
    begin
      int bad = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0 || bus_req !== 1'b0) bad++;
      end
      total++;
      if (bad != 0 || rx_q.size() != 0) $display("FAIL reset_idle got bad=%0d rx=%0d want 0 0", bad, rx_q.size());
      else passed++;
    end
  endtask

  task automatic test_single;
    logic [7:0] b = 8'hA5;
    int bad = 0, r0 = rx_q.size();
    logic exp;
    mem[8'h10] = b;
    kick(8'h10, 9'd1);
    total++;
    if (mem_addr !== 8'h10 || bus_req !== 1'b1 || busy !== 1'b1)
      $display("FAIL single_addr got mem_addr=%h bus_req=%b busy=%b want 10 1 1", mem_addr, bus_req, busy);
    else passed++;
    for (int k = 2; k <= 43; k++) begin
      @(negedge clk);
      exp = (k >= 4 && k < 8) ? 1'b0 : (k >= 8 && k < 40) ? b[(k-8)/4] : 1'b1;
      if (tx !== exp || done !== 1'b0) bad++;
      if (k == 4) begin
        total++;
        if (tx !== 1'b0 || bus_req !== 1'b0) $display("FAIL single_start_bit got tx=%b bus_req=%b want 0 0", tx, bus_req);
        else passed++;
      end
    end
    total++;
    if (bad != 0) $display("FAIL single_waveform got %0d bad cycles want 0", bad);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL single_done got done=%b busy=%b want 1 0", done, busy);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || rx_q.size() != r0 + 1 || rx_q[r0] !== 8'hA5)
      $display("FAIL single_byte got done=%b rx_n=%0d byte=%h want 0 1 a5", done, rx_q.size() - r0, rx_q.size() > r0 ? rx_q[r0] : 8'hxx);
    else passed++;
  endtask

  task automatic test_wrap;
    int r0 = rx_q.size(), a0 = addr_q.size(), d0 = done_cnt;
    mem[8'hFE] = 8'h01;
    mem[8'hFF] = 8'h80;
    mem[8'h00] = 8'h3C;
    kick(8'hFE, 9'd3);
    wait_done(400);
    repeat (5) @(negedge clk);
    total++;
    if (addr_q.size() != a0 + 3 || addr_q[a0] !== 8'hFE || addr_q[a0+1] !== 8'hFF || addr_q[a0+2] !== 8'h00)
      $display("FAIL wrap_addrs got n=%0d want fe ff 00", addr_q.size() - a0);
    else passed++;
    total++;
    if (rx_q.size() != r0 + 3 || rx_q[r0] !== 8'h01 || rx_q[r0+1] !== 8'h80 || rx_q[r0+2] !== 8'h3C)
      $display("FAIL wrap_bytes got n=%0d want 01 80 3c", rx_q.size() - r0);
    else passed++;
    total++;
    if (done_cnt - d0 != 1 || frame_err != 0) $display("FAIL wrap_done got done=%0d ferr=%0d want 1 0", done_cnt - d0, frame_err);
    else passed++;
  endtask

  task automatic test_count0;
    int a0 = addr_q.size(), d0 = done_cnt;
    kick(8'h40, 9'd0);
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || bus_req !== 1'b0 || tx !== 1'b1)
      $display("FAIL count0_t1 got done=%b busy=%b bus_req=%b tx=%b want 1 1 0 1", done, busy, bus_req, tx);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) $display("FAIL count0_t2 got done=%b busy=%b tx=%b want 0 0 1", done, busy, tx);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (addr_q.size() != a0 || done_cnt - d0 != 1) $display("FAIL count0_bus got reads=%0d dones=%0d want 0 1", addr_q.size() - a0, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_start_busy;
    int r0 = rx_q.size(), a0 = addr_q.size(), d0 = done_cnt;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h22;
    kick(8'h20, 9'd2);
    repeat (10) @(negedge clk);
    kick(8'h00, 9'd5);
    wait_done(400);
    repeat (100) @(negedge clk);
    total++;
    if (rx_q.size() != r0 + 2 || rx_q[r0] !== 8'h11 || rx_q[r0+1] !== 8'h22)
      $display("FAIL busy_bytes got n=%0d want 2 bytes 11 22", rx_q.size() - r0);
    else passed++;
    total++;
    if (addr_q.size() != a0 + 2 || addr_q[a0] !== 8'h20 || addr_q[a0+1] !== 8'h21 || done_cnt - d0 != 1 || busy !== 1'b0)
      $display("FAIL busy_addrs got reads=%0d dones=%0d busy=%b want 2 1 0", addr_q.size() - a0, done_cnt - d0, busy);
    else passed++;
  endtask

  task automatic test_mid_reset;
    int r0 = rx_q.size(), d0 = done_cnt, e0 = frame_err;
    mem[8'h30] = 8'h52;
    kick(8'h30, 9'd1);
    repeat (20) @(negedge clk);
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL midrst_bit3 got tx=%b busy=%b want 0 1", tx, busy);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst_after got tx=%b busy=%b bus_req=%b done=%b want 1 0 0 0", tx, busy, bus_req, done);
    else passed++;
    repeat (60) @(negedge clk);
    total++;
    if (done_cnt != d0 || rx_q.size() != r0 || frame_err != e0)
      $display("FAIL midrst_quiet got dones=%0d bytes=%0d ferr=%0d want 0 0 0", done_cnt - d0, rx_q.size() - r0, frame_err - e0);
    else passed++;
    kick(8'h30, 9'd1);
    wait_done(200);
    repeat (3) @(negedge clk);
    total++;
    if (rx_q.size() != r0 + 1 || rx_q[r0] !== 8'h52 || done_cnt - d0 != 1)
      $display("FAIL midrst_fresh got bytes=%0d dones=%0d want 1 byte 52 and 1 done", rx_q.size() - r0, done_cnt - d0);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    test_reset;
    test_single;
    test_wrap;
    test_count0;
    test_start_busy;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
